// File: rtl/regfile_pkg.sv
// Shared constants and byte-merge helper for the register file and its storage entries.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS   = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;

  // Widest word the merge helper handles; callers widen their operands and truncate the result.
  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] new_data,
    input logic [MAX_BYTES-1:0]      mask
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One storage word with byte-masked write, synchronous clear and a power-up value.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH/8-1:0] byte_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  // Power-up value only; clear always returns the word to zero.
  logic [DATA_WIDTH-1:0] data_q = INIT;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    data_d = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(data_q),
                                    MAX_DATA_WIDTH'(wr_data_i),
                                    MAX_BYTES'(byte_en_i)));
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      data_q <= '0;
    end else if (wr_en_i) begin
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/register_file.sv
// Multi-entry register file: one byte-masked write port, two combinational read ports,
// optional hardwired-zero entry 0 and optional write-first bypass.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1,
  parameter logic [31:0] INIT       = 32'h0
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH/8-1:0] write_byte_en,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [ADDR_WIDTH-1:0]   read_addr_a,
  output logic [DATA_WIDTH-1:0]   read_data_a,
  input  logic [ADDR_WIDTH-1:0]   read_addr_b,
  output logic [DATA_WIDTH-1:0]   read_data_b
);

  localparam logic [DATA_WIDTH-1:0] INIT_W = DATA_WIDTH'(INIT);

  logic [DATA_WIDTH-1:0] entry_data [NUM_REGS];
  logic                  wr_valid_c;

  // A write lands only if it has bytes to write and targets an existing, writable entry.
  always_comb begin
    wr_valid_c = write_enable
              && (|write_byte_en)
              && (32'(write_addr) < NUM_REGS)
              && !(ZERO_REG && (write_addr == '0));
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign entry_data[g] = '0;
    end else begin : g_store
      regfile_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .INIT       (INIT_W)
      ) u_entry (
        .clock     (clock),
        .clear     (clear),
        .wr_en_i   (wr_valid_c && (write_addr == ADDR_WIDTH'(g))),
        .byte_en_i (write_byte_en),
        .wr_data_i (write_data),
        .rd_data_o (entry_data[g])
      );
    end
  end

  // Stored word (zero when out of range), optionally overlaid with the in-flight write.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0]   addr,
    input logic [DATA_WIDTH-1:0]   words [NUM_REGS],
    input logic                    wr_valid,
    input logic [ADDR_WIDTH-1:0]   wr_addr,
    input logic [DATA_WIDTH/8-1:0] wr_be,
    input logic [DATA_WIDTH-1:0]   wr_data
  );
    logic [DATA_WIDTH-1:0] stored;
    stored = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) stored = words[i];
    end
    if (BYPASS && wr_valid && (addr == wr_addr)) begin
      return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(stored),
                                    MAX_DATA_WIDTH'(wr_data),
                                    MAX_BYTES'(wr_be)));
    end
    return stored;
  endfunction

  always_comb begin
    read_data_a = read_port(read_addr_a, entry_data, wr_valid_c,
                            write_addr, write_byte_en, write_data);
    read_data_b = read_port(read_addr_b, entry_data, wr_valid_c,
                            write_addr, write_byte_en, write_data);
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: two register_file configurations share stimulus and are checked
// against an array-based reference model on both read ports.
module tb_register_file;

  logic        clock = 1'b0;
  logic        clear;
  logic        write_enable;
  logic [3:0]  write_addr;
  logic [3:0]  write_byte_en;
  logic [31:0] write_data;
  logic [3:0]  read_addr_a;
  logic [3:0]  read_addr_b;
  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;

  always #5 clock = ~clock;

  // Config 0: 12 entries, hardwired zero, bypass. Config 1: 16 entries, no zero reg, read-old.
  register_file #(
    .DATA_WIDTH(32), .NUM_REGS(12), .ADDR_WIDTH(4),
    .ZERO_REG(1'b1), .BYPASS(1'b1), .INIT(32'hDEAD_BEEF)
  ) u_dut0 (
    .clock(clock), .clear(clear), .write_enable(write_enable),
    .write_addr(write_addr), .write_byte_en(write_byte_en), .write_data(write_data),
    .read_addr_a(read_addr_a), .read_data_a(rd_a0),
    .read_addr_b(read_addr_b), .read_data_b(rd_b0)
  );

  register_file #(
    .DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4),
    .ZERO_REG(1'b0), .BYPASS(1'b0), .INIT(32'hCAFE_F00D)
  ) u_dut1 (
    .clock(clock), .clear(clear), .write_enable(write_enable),
    .write_addr(write_addr), .write_byte_en(write_byte_en), .write_data(write_data),
    .read_addr_a(read_addr_a), .read_data_a(rd_a1),
    .read_addr_b(read_addr_b), .read_data_b(rd_b1)
  );

  // Reference model
  int unsigned cfg_nregs  [2] = '{12, 16};
  bit          cfg_zero   [2] = '{1'b1, 1'b0};
  bit          cfg_bypass [2] = '{1'b1, 1'b0};
  logic [31:0] mem [2][16];

  function automatic bit writable(int c, logic [3:0] a);
    return (int'(a) < int'(cfg_nregs[c])) && !(cfg_zero[c] && a == 4'd0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  function automatic bit write_lands(int c);
    return write_enable && (write_byte_en != 4'd0) && writable(c, write_addr);
  endfunction

  function automatic logic [31:0] model_read(int c, logic [3:0] a);
    logic [31:0] v;
    v = writable(c, a) ? mem[c][a] : 32'h0;
    if (cfg_bypass[c] && write_lands(c) && a == write_addr) v = merge(v, write_data, write_byte_en);
    return v;
  endfunction

  function automatic void model_commit();
    for (int c = 0; c < 2; c++) begin
      if (clear) begin
        for (int i = 0; i < 16; i++) mem[c][i] = 32'h0;
      end else if (write_lands(c)) begin
        mem[c][write_addr] = merge(mem[c][write_addr], write_data, write_byte_en);
      end
    end
  endfunction

  // Scoreboard
  typedef struct {
    string       tag;
    logic [31:0] a0, b0, a1, b1;
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, " dut0.a"}, rd_a0, e.a0);
      check({e.tag, " dut0.b"}, rd_b0, e.b0);
      check({e.tag, " dut1.a"}, rd_a1, e.a1);
      check({e.tag, " dut1.b"}, rd_b1, e.b1);
    end
  end

  // Drive one cycle just after the edge, queue expectations, then advance the model.
  task automatic step(string tag, logic clr, logic we, logic [3:0] wa, logic [3:0] be,
                      logic [31:0] wd, logic [3:0] ra, logic [3:0] rb);
    exp_t e;
    @(posedge clock);
    #1;
    clear = clr; write_enable = we; write_addr = wa; write_byte_en = be;
    write_data = wd; read_addr_a = ra; read_addr_b = rb;
    e.tag = tag;
    e.a0 = model_read(0, ra); e.b0 = model_read(0, rb);
    e.a1 = model_read(1, ra); e.b1 = model_read(1, rb);
    sb_q.push_back(e);
    model_commit();
  endtask

  initial begin
    clear = 1'b0; write_enable = 1'b0; write_addr = 4'd0; write_byte_en = 4'd0;
    write_data = 32'h0; read_addr_a = 4'd5; read_addr_b = 4'd0;
    for (int i = 0; i < 16; i++) begin
      mem[0][i] = 32'hDEAD_BEEF;
      mem[1][i] = 32'hCAFE_F00D;
    end

    step("powerup",   1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd5,  4'd0);
    step("clear",     1'b1, 1'b0, 4'd0,  4'h0, 32'h0,         4'd5,  4'd0);
    step("postclr",   1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd5,  4'd0);
    step("wr_r3",     1'b0, 1'b1, 4'd3,  4'hF, 32'h1234_5678, 4'd3,  4'd3);
    step("wr_r3_be",  1'b0, 1'b1, 4'd3,  4'h5, 32'hAABB_CCDD, 4'd3,  4'd3);
    step("rd_r3",     1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd3,  4'd3);
    step("wr_r7",     1'b0, 1'b1, 4'd7,  4'hF, 32'h1111_1111, 4'd7,  4'd3);
    step("byp_r7",    1'b0, 1'b1, 4'd7,  4'h8, 32'h2222_2222, 4'd7,  4'd7);
    step("rd_r7",     1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd7,  4'd3);
    step("wr_be0",    1'b0, 1'b1, 4'd7,  4'h0, 32'h3333_3333, 4'd7,  4'd7);
    step("wr_r0",     1'b0, 1'b1, 4'd0,  4'hF, 32'hFFFF_FFFF, 4'd0,  4'd7);
    step("rd_r0",     1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd0,  4'd0);
    step("wr_r2",     1'b0, 1'b1, 4'd2,  4'hF, 32'h9999_9999, 4'd2,  4'd3);
    step("clr_wr_r2", 1'b1, 1'b1, 4'd2,  4'hF, 32'h0000_0055, 4'd2,  4'd3);
    step("rd_r2",     1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd2,  4'd3);
    step("wr_r11",    1'b0, 1'b1, 4'd11, 4'hF, 32'h0BAD_F00D, 4'd11, 4'd11);
    step("wr_a13",    1'b0, 1'b1, 4'd13, 4'hF, 32'h1313_1313, 4'd13, 4'd11);
    step("rd_a13",    1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         4'd13, 4'd11);

    for (int n = 0; n < 10000; n++) begin
      logic [3:0] wa, ra, rb;
      wa = 4'($urandom_range(15));
      ra = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
      rb = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
      step("rand", ($urandom_range(63) == 0), 1'($urandom_range(1)), wa,
           4'($urandom_range(15)), $urandom, ra, rb);
    end

    for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clock);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
